// File: rtl/reg_bank_read.sv
// 32-entry GPR bank with two registered read ports (rs, rt); read latency 1 clock, one read per clock.
// No backpressure: a read request always completes on the next edge, and writes to the same index bypass into that read.
module reg_bank_read #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_INDEX = 29,
  parameter int SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rs_next;
  logic [DATA_W-1:0] rt_next;
  logic              wr_commit;

  // Index 0 is hardwired to zero: never written, never bypassed.
  assign wr_commit = we && (wr_addr != '0);

  always_comb begin
    rs_next = '0;
    if (rs_addr != '0) begin
      rs_next = (wr_commit && (wr_addr == rs_addr)) ? wr_data : regs[rs_addr];
    end
  end

  always_comb begin
    rt_next = '0;
    if (rt_addr != '0) begin
      rt_next = (wr_commit && (wr_addr == rt_addr)) ? wr_data : regs[rt_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_data  <= '0;
      rt_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rs_data <= rs_next;
        rt_data <= rt_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_read.sv
// Bench for reg_bank_read: reference register model plus a read-result scoreboard.
module tb_reg_bank_read;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_valid;

  reg_bank_read #(
    .DATA_W(32), .ADDR_W(5), .SP_INDEX(29), .SP_RESET(227)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [32];
  logic [31:0] hold_rs;
  logic [31:0] hold_rt;
  int          checks;
  int          errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic w, input logic [4:0] wa,
                                          input logic [31:0] wd, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (w && wa == a) return wd;
    return mdl[a];
  endfunction

  // One clock: drive at negedge, update model at posedge, check outputs just after.
  task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic re, input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    @(negedge clk);
    reset = r; we = w; wr_addr = wa; wr_data = wd; rd_en = re; rs_addr = ra; rt_addr = rb;
    e.rs = exp_rd(w, wa, wd, ra);
    e.rt = exp_rd(w, wa, wd, rb);
    if (re && !r) sb_q.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? 32'd227 : 32'd0;
      hold_rs = 32'd0;
      hold_rt = 32'd0;
    end else begin
      if (w && wa != 5'd0) mdl[wa] = wd;
      if (re) begin
        hold_rs = e.rs;
        hold_rt = e.rt;
      end
    end
    #2;
    check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, re && !r});
    check_eq("rs_data_cyc", rs_data, hold_rs);
    check_eq("rt_data_cyc", rt_data, hold_rt);
  endtask

  always @(posedge clk) begin
    #1;
    if (rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("valid_without_req", {31'd0, rd_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_rs", rs_data, e.rs);
        check_eq("sb_rt", rt_data, e.rt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0;
    hold_rs = 32'd0; hold_rt = 32'd0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    reset = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rs_addr = '0; rt_addr = '0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // SP reset value and zero register.
    cyc(0, 0, 0, 0, 1, 29, 31);
    check_eq("sp_reset_rs", rs_data, 32'd227);
    check_eq("r31_reset_rt", rt_data, 32'd0);
    // Write then read.
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 5, 29);
    check_eq("wr_then_rd", rs_data, 32'hDEADBEEF);
    // Same-edge bypass on both ports, then persistent value.
    cyc(0, 1, 7, 32'h12345678, 1, 7, 7);
    check_eq("bypass_rs", rs_data, 32'h12345678);
    check_eq("bypass_rt", rt_data, 32'h12345678);
    cyc(0, 0, 0, 0, 1, 0, 7);
    check_eq("r7_persist", rt_data, 32'h12345678);
    // Index 0 never written nor bypassed.
    cyc(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
    check_eq("r0_bypass", rs_data, 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 5);
    check_eq("r0_later", rs_data, 32'd0);
    // Reset overrides concurrent write and read.
    cyc(0, 1, 3, 32'hA5A5A5A5, 0, 0, 0);
    cyc(1, 1, 3, 32'd1, 1, 3, 3);
    check_eq("rst_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_rs", rs_data, 32'd0);
    cyc(0, 0, 0, 0, 1, 3, 29);
    check_eq("r3_after_rst", rs_data, 32'd0);
    check_eq("sp_after_rst", rt_data, 32'd227);
    // Single pulse then hold while the rs register is rewritten.
    cyc(0, 1, 9, 32'h0BADF00D, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 9, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 9, 32'h1000 + i, 0, 9, 0);
      check_eq("hold_rs", rs_data, 32'h0BADF00D);
    end
    // Back-to-back reads.
    for (int i = 1; i < 8; i++) cyc(0, 1, 5'(i + 10), 32'hC0DE0000 + i, 1, 5'(i + 10), 5'(i + 9));
    // Random traffic on a small address set to hit bypass often.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a[3];
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 3))
          0: a[k] = 5'd0;
          1: a[k] = 5'd29;
          default: a[k] = 5'($urandom_range(1, 6));
        endcase
      end
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), a[0], $urandom,
          ($urandom_range(0, 2) != 0), a[1], a[2]);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
